// File: rtl/aemb_wb_arb.sv
// aemb_wb_arb: fair two-master Wishbone arbiter with registered slave port and ack watchdog
module aemb_wb_arb #(
  parameter int AW   = 32,
  parameter int TMO  = 255,
  parameter int TMOW = 8
) (
  input  logic          sys_clk_i,
  input  logic          sys_rst_i,
  input  logic          iwb_stb_i,
  input  logic [AW-3:0] iwb_adr_i,
  output logic          iwb_ack_o,
  output logic [31:0]   iwb_dat_o,
  input  logic          dwb_stb_i,
  input  logic          dwb_wre_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [AW-3:0] dwb_adr_i,
  input  logic [31:0]   dwb_dat_i,
  output logic          dwb_ack_o,
  output logic [31:0]   dwb_dat_o,
  output logic          mwb_stb_o,
  output logic          mwb_wre_o,
  output logic [3:0]    mwb_sel_o,
  output logic [AW-3:0] mwb_adr_o,
  output logic [31:0]   mwb_dat_o,
  input  logic          mwb_ack_i,
  input  logic [31:0]   mwb_dat_i,
  output logic [1:0]    arb_gnt_o,
  output logic          arb_tmo_o
);
  typedef enum logic [1:0] {IDLE, IGNT, DGNT, DONE} state_t;
  state_t          r_state, w_state;
  logic            r_last, w_last;
  logic [TMOW-1:0] r_cnt, w_cnt;
  logic            w_iack, w_dack, w_tmo, w_stb, w_wre;
  logic [31:0]     w_idat, w_ddat, w_mdat;
  logic [3:0]      w_sel;
  logic [AW-3:0]   w_adr;
  logic [1:0]      w_gnt;
  logic            w_busy, w_pick_d, w_exp, w_fin;
  assign w_busy   = (r_state == IGNT) || (r_state == DGNT);
  // r_last high means dwb held the bus last, so iwb wins a tie
  assign w_pick_d = dwb_stb_i && (!iwb_stb_i || !r_last);
  assign w_exp    = (TMO != 0) && (r_cnt == TMOW'(TMO));
  assign w_fin    = w_busy && (mwb_ack_i || w_exp);
  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_cnt   = r_cnt;
    w_iack  = 1'b0;
    w_dack  = 1'b0;
    w_tmo   = 1'b0;
    w_stb   = mwb_stb_o;
    w_wre   = mwb_wre_o;
    w_sel   = mwb_sel_o;
    w_adr   = mwb_adr_o;
    w_mdat  = mwb_dat_o;
    w_idat  = iwb_dat_o;
    w_ddat  = dwb_dat_o;
    w_gnt   = arb_gnt_o;
    if (r_state == IDLE && (iwb_stb_i || dwb_stb_i)) begin
      w_state = w_pick_d ? DGNT : IGNT;
      w_last  = w_pick_d;
      w_cnt   = '0;
      w_stb   = 1'b1;
      w_gnt   = {w_pick_d, !w_pick_d};
      w_adr   = w_pick_d ? dwb_adr_i : iwb_adr_i;
      w_wre   = w_pick_d && dwb_wre_i;
      w_sel   = w_pick_d ? dwb_sel_i : 4'hF;
      w_mdat  = w_pick_d ? dwb_dat_i : 32'h0;
    end else if (w_fin) begin
      w_state = DONE;
      w_stb   = 1'b0;
      w_tmo   = !mwb_ack_i;
      w_iack  = r_state == IGNT;
      w_dack  = r_state == DGNT;
      w_idat  = (r_state == IGNT) ? (mwb_ack_i ? mwb_dat_i : 32'h0) : iwb_dat_o;
      w_ddat  = (r_state == DGNT) ? (mwb_ack_i ? mwb_dat_i : 32'h0) : dwb_dat_o;
    end else if (w_busy) begin
      w_cnt   = r_cnt + TMOW'(r_cnt != '1);
    end else if (r_state == DONE) begin
      w_state = IDLE;
      w_gnt   = 2'b00;
    end
  end
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state   <= IDLE;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      iwb_ack_o <= 1'b0;
      dwb_ack_o <= 1'b0;
      iwb_dat_o <= '0;
      dwb_dat_o <= '0;
      mwb_stb_o <= 1'b0;
      mwb_wre_o <= 1'b0;
      mwb_sel_o <= '0;
      mwb_adr_o <= '0;
      mwb_dat_o <= '0;
      arb_gnt_o <= '0;
      arb_tmo_o <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_last    <= w_last;
      r_cnt     <= w_cnt;
      iwb_ack_o <= w_iack;
      dwb_ack_o <= w_dack;
      iwb_dat_o <= w_idat;
      dwb_dat_o <= w_ddat;
      mwb_stb_o <= w_stb;
      mwb_wre_o <= w_wre;
      mwb_sel_o <= w_sel;
      mwb_adr_o <= w_adr;
      mwb_dat_o <= w_mdat;
      arb_gnt_o <= w_gnt;
      arb_tmo_o <= w_tmo;
    end
  end
endmodule

// File: tb/tb_aemb_wb_arb.sv
// tb_aemb_wb_arb: randomized and directed checks of aemb_wb_arb against a transaction-timeline model
module tb_aemb_wb_arb;
  localparam int AW = 32, TMO = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic iwb_stb = 1'b0;
  logic [AW-3:0] iwb_adr = '0;
  logic dwb_stb = 1'b0, dwb_wre = 1'b0;
  logic [3:0] dwb_sel = '0;
  logic [AW-3:0] dwb_adr = '0;
  logic [31:0] dwb_wdat = '0;
  logic mwb_ack = 1'b0;
  logic [31:0] mwb_rdat = '0;
  logic iwb_ack, dwb_ack, mwb_stb, mwb_wre, tmo;
  logic [31:0] iwb_dat, dwb_dat, mwb_dat;
  logic [3:0] mwb_sel;
  logic [AW-3:0] mwb_adr;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  aemb_wb_arb #(.AW(AW), .TMO(TMO), .TMOW(8)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst_n),
    .iwb_stb_i(iwb_stb), .iwb_adr_i(iwb_adr), .iwb_ack_o(iwb_ack), .iwb_dat_o(iwb_dat),
    .dwb_stb_i(dwb_stb), .dwb_wre_i(dwb_wre), .dwb_sel_i(dwb_sel), .dwb_adr_i(dwb_adr),
    .dwb_dat_i(dwb_wdat), .dwb_ack_o(dwb_ack), .dwb_dat_o(dwb_dat),
    .mwb_stb_o(mwb_stb), .mwb_wre_o(mwb_wre), .mwb_sel_o(mwb_sel), .mwb_adr_o(mwb_adr),
    .mwb_dat_o(mwb_dat), .mwb_ack_i(mwb_ack), .mwb_dat_i(mwb_rdat),
    .arb_gnt_o(gnt), .arb_tmo_o(tmo)
  );

  int checks = 0, errors = 0;
  // model: owner 0 none / 1 iwb / 2 dwb, edges since grant, planned slave wait states
  int m_own, m_k, m_w;
  bit m_fin, m_last;
  logic [31:0] m_rdat;
  logic e_iack, e_dack, e_stb, e_wre, e_tmo;
  logic [31:0] e_idat, e_ddat, e_mdat;
  logic [3:0] e_sel;
  logic [AW-3:0] e_adr;
  logic [1:0] e_gnt;
  int next_w = 0;
  logic [31:0] next_rdat = '0;
  bit rnd = 0, stop_new = 0;
  int waits[2];
  logic [1:0] prev_gnt = 2'b00;
  int ireqs = 0, iacks = 0, dreqs = 0, dacks = 0;

  task automatic chk(input string n, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  task automatic chk_zero(input string n);
    chk(n, {iwb_ack, dwb_ack, iwb_dat, dwb_dat, mwb_stb, mwb_wre, mwb_sel, mwb_adr, mwb_dat, gnt, tmo}, '0);
  endtask

  task automatic model_reset();
    m_own = 0; m_k = 0; m_w = 0; m_fin = 0; m_last = 0; m_rdat = '0;
    e_iack = 0; e_dack = 0; e_stb = 0; e_wre = 0; e_tmo = 0;
    e_idat = '0; e_ddat = '0; e_mdat = '0; e_sel = '0; e_adr = '0; e_gnt = '0;
  endtask

  // a transfer granted at edge g completes at edge g+1+min(wait,TMO); it times out only if wait > TMO
  task automatic model_edge();
    logic [31:0] d;
    bit pick_d;
    e_iack = 0; e_dack = 0; e_tmo = 0;
    if (!rst_n) model_reset();
    else if (m_fin) begin
      m_own = 0; m_fin = 0; e_gnt = 2'b00;
    end else if (m_own != 0) begin
      m_k++;
      if (m_k == 1 + ((m_w < TMO) ? m_w : TMO)) begin
        d = (m_w <= TMO) ? m_rdat : 32'h0;
        m_fin = 1; e_stb = 0; e_tmo = (m_w > TMO);
        if (m_own == 1) begin e_iack = 1; e_idat = d; end
        else begin e_dack = 1; e_ddat = d; end
      end
    end else if (iwb_stb || dwb_stb) begin
      pick_d = (iwb_stb && dwb_stb) ? !m_last : dwb_stb;
      m_own = pick_d ? 2 : 1; m_last = pick_d; m_k = 0; m_w = next_w; m_rdat = next_rdat;
      e_stb = 1; e_gnt = pick_d ? 2'b10 : 2'b01;
      e_adr = pick_d ? dwb_adr : iwb_adr;
      e_wre = pick_d && dwb_wre;
      e_sel = pick_d ? dwb_sel : 4'hF;
      e_mdat = pick_d ? dwb_wdat : 32'h0;
    end
  endtask

  task automatic compare();
    chk("iwb_ack", iwb_ack, e_iack);
    chk("dwb_ack", dwb_ack, e_dack);
    chk("iwb_dat", iwb_dat, e_idat);
    chk("dwb_dat", dwb_dat, e_ddat);
    chk("mwb_stb", mwb_stb, e_stb);
    chk("mwb_wre", mwb_wre, e_wre);
    chk("mwb_sel", mwb_sel, e_sel);
    chk("mwb_adr", mwb_adr, e_adr);
    chk("mwb_dat", mwb_dat, e_mdat);
    chk("arb_gnt", gnt, e_gnt);
    chk("arb_tmo", tmo, e_tmo);
    if (!rst_n) begin
      waits[0] = 0; waits[1] = 0;
    end else if (gnt != prev_gnt && gnt == 2'b01) begin
      if (dwb_stb) begin waits[1]++; chk("fair_dwb", waits[1] <= 1, 1); end
      waits[0] = 0;
    end else if (gnt != prev_gnt && gnt == 2'b10) begin
      if (iwb_stb) begin waits[0]++; chk("fair_iwb", waits[0] <= 1, 1); end
      waits[1] = 0;
    end
    prev_gnt = gnt;
  endtask

  task automatic masters();
    if (iwb_ack) begin chk("iwb_ack_pending", iwb_stb, 1); iacks++; iwb_stb = 0; end
    if (dwb_ack) begin chk("dwb_ack_pending", dwb_stb, 1); dacks++; dwb_stb = 0; end
    if (!stop_new && !iwb_stb && $urandom_range(0, 3) != 0) begin
      iwb_stb = 1; iwb_adr = (AW-2)'($urandom); ireqs++;
    end
    if (!stop_new && !dwb_stb && $urandom_range(0, 3) != 0) begin
      dwb_stb = 1; dwb_adr = (AW-2)'($urandom); dwb_wre = 1'($urandom);
      dwb_sel = 4'($urandom); dwb_wdat = $urandom; dreqs++;
    end
  endtask

  task automatic step();
    if (rnd) begin next_w = $urandom_range(0, 6); next_rdat = $urandom; end
    mwb_ack = rst_n && m_own != 0 && !m_fin && m_k == m_w;
    mwb_rdat = mwb_ack ? m_rdat : $urandom;
    @(posedge clk); #1;
    model_edge();
    compare();
    if (rnd) masters();
  endtask

  task automatic wait_ack(input bit d, output int n);
    n = 0;
    do begin step(); n++; end while (!(d ? dwb_ack : iwb_ack) && n < 12);
  endtask

  task automatic do_reset();
    rst_n = 0; iwb_stb = 0; dwb_stb = 0;
    step(); step();
    rst_n = 1;
    step();
  endtask

  initial begin
    int n;
    logic [1:0] seq[$];
    logic [1:0] pg;
    logic [1:0] exp_seq[5];
    exp_seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    model_reset();
    step();
    chk_zero("reset_state");
    rst_n = 1;
    step();

    next_w = 0; next_rdat = 32'hB0000010;
    iwb_stb = 1; iwb_adr = 'h100;
    wait_ack(0, n);
    chk("iwb_read_lat", n, 2);
    chk("iwb_read_dat", iwb_dat, 32'hB0000010);
    chk("iwb_read_wre", mwb_wre, 0);
    chk("iwb_read_sel", mwb_sel, 4'hF);
    iwb_stb = 0;
    step();
    chk("iwb_read_done", {iwb_ack, gnt}, 0);

    next_w = 3; next_rdat = 32'h0BAD0BAD;
    dwb_stb = 1; dwb_wre = 1; dwb_sel = 4'h3; dwb_adr = 'h200; dwb_wdat = 32'h1234ABCD;
    step();
    chk("dwb_wr_bus", {mwb_stb, mwb_wre, mwb_sel, mwb_adr, mwb_dat}, {1'b1, 1'b1, 4'h3, 30'h200, 32'h1234ABCD});
    wait_ack(1, n);
    chk("dwb_wr_lat", n + 1, 5);
    chk("dwb_wr_dat", dwb_dat, 32'h0BAD0BAD);
    dwb_stb = 0;
    step(); step();

    do_reset();
    next_w = 0; next_rdat = 32'hCAFE0001;
    iwb_stb = 1; dwb_stb = 1; dwb_wre = 0;
    pg = gnt;
    for (int i = 0; i < 7; i++) begin
      step();
      if (gnt != pg) seq.push_back(gnt);
      pg = gnt;
    end
    chk("gnt_seq_len", seq.size(), 5);
    for (int i = 0; i < 5; i++) if (i < seq.size()) chk("gnt_seq", seq[i], exp_seq[i]);
    wait_ack(1, n);
    iwb_stb = 0; dwb_stb = 0;
    step(); step();

    next_w = 100;
    iwb_stb = 1; iwb_adr = 'h55;
    step();
    chk("wdog_gnt", gnt, 2'b01);
    wait_ack(0, n);
    chk("wdog_lat", n, 5);
    chk("wdog_tmo", tmo, 1);
    chk("wdog_dat", iwb_dat, 32'h0);
    iwb_stb = 0;
    step(); step();

    next_w = TMO; next_rdat = 32'hA5A50004;
    dwb_stb = 1; dwb_wre = 0; dwb_adr = 'h33;
    step();
    wait_ack(1, n);
    chk("wdog_race_lat", n, 5);
    chk("wdog_race_tmo", tmo, 0);
    chk("wdog_race_dat", dwb_dat, 32'hA5A50004);
    dwb_stb = 0;
    step(); step();

    next_w = 20;
    dwb_stb = 1; dwb_wre = 1; dwb_adr = 'h44;
    step(); step(); step();
    chk("rst_mid_busy", {mwb_stb, gnt}, 3'b110);
    #3 rst_n = 0;
    #1 chk_zero("rst_async");
    model_reset();
    dwb_stb = 0;
    step();
    chk_zero("rst_held");
    rst_n = 1;
    next_w = 1; next_rdat = 32'h600D0001;
    iwb_stb = 1; iwb_adr = 'h7;
    wait_ack(0, n);
    chk("post_rst_lat", n, 3);
    chk("post_rst_dat", iwb_dat, 32'h600D0001);
    iwb_stb = 0;
    step(); step();

    rnd = 1;
    for (int c = 0; c < 20000 && iacks + dacks < 1000; c++) step();
    stop_new = 1;
    for (int c = 0; c < 40; c++) step();
    chk("rand_xfers", iacks + dacks >= 1000, 1);
    chk("iwb_one_ack_each", iacks, ireqs);
    chk("dwb_one_ack_each", dacks, dreqs);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
